// File: rtl/branch_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// branch_sequencer_pkg
// Shared definitions for the branch sequencer slice:
//   - OP_* opcode encodings shared between decode and the branch path
//   - sequencer state encodings and the state enum built from them
//   - helpers to classify an opcode
// -----------------------------------------------------------------------------
package branch_sequencer_pkg;

  // Decoded opcode encodings for the branch family.
  localparam logic [4:0] OP_B   = 5'h10;
  localparam logic [4:0] OP_BL  = 5'h11;
  localparam logic [4:0] OP_BEQ = 5'h12;
  localparam logic [4:0] OP_BNE = 5'h13;

  // Sequencer state encodings.
  localparam logic [2:0] ST_IDLE_ENC     = 3'd0;
  localparam logic [2:0] ST_FETCH_ENC    = 3'd1;
  localparam logic [2:0] ST_RESOLVE_ENC  = 3'd2;
  localparam logic [2:0] ST_REDIRECT_ENC = 3'd3;
  localparam logic [2:0] ST_FLUSH_ENC    = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE     = ST_IDLE_ENC,
    ST_FETCH    = ST_FETCH_ENC,
    ST_RESOLVE  = ST_RESOLVE_ENC,
    ST_REDIRECT = ST_REDIRECT_ENC,
    ST_FLUSH    = ST_FLUSH_ENC
  } seq_state_e;

  function automatic logic is_branch_op(input logic [4:0] op);
    return (op == OP_B) || (op == OP_BL) || (op == OP_BEQ) || (op == OP_BNE);
  endfunction

  function automatic logic is_cond_op(input logic [4:0] op);
    return (op == OP_BEQ) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/branch_calculator.sv
// -----------------------------------------------------------------------------
// branch_calculator
// Purely combinational branch target / link computation.
//   dec_pc     in  32 : address of the decoded instruction
//   dec_offset in  24 : raw word offset field (signed)
//   dec_opcode in   5 : decoded opcode
//   target     out 32 : dec_pc + 8 + sext(dec_offset) * 4, modulo 2^32
//   link_addr  out 32 : dec_pc + 4
//   is_branch  out  1 : opcode is B, BL, BEQ or BNE
//   is_cond    out  1 : opcode is BEQ or BNE
// -----------------------------------------------------------------------------
module branch_calculator
  import branch_sequencer_pkg::*;
(
  input  logic [31:0] dec_pc,
  input  logic [23:0] dec_offset,
  input  logic [4:0]  dec_opcode,
  output logic [31:0] target,
  output logic [31:0] link_addr,
  output logic        is_branch,
  output logic        is_cond
);

  // Sign-extend the word offset and convert it to a byte offset in one step.
  logic [31:0] byte_offset;
  assign byte_offset = {{6{dec_offset[23]}}, dec_offset, 2'b00};

  // Plain unsigned adds: a negative offset crossing zero simply wraps.
  assign target    = dec_pc + 32'd8 + byte_offset;
  assign link_addr = dec_pc + 32'd4;
  assign is_branch = is_branch_op(dec_opcode);
  assign is_cond   = is_cond_op(dec_opcode);

endmodule

// File: rtl/branch_sequencer.sv
// -----------------------------------------------------------------------------
// branch_sequencer
// Owns the architectural PC: issues sequential fetches, accepts branches from
// decode, waits for execute flags on conditional branches, then redirects the
// PC, flushes younger stages and writes the link register for BL.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   fetch_req/fetch_addr (out) : fetch request and address (addr == pc)
//   fetch_ack, stall     (in)  : fetch handshake, decode back-pressure
//   dec_valid/opcode/offset/pc : decoded instruction from decode
//   flags_valid, flag_z  (in)  : resolved flags from execute
//   flush                (out) : kill younger in-flight instructions
//   link_we, link_data   (out) : link-register write for BL
//   pc                   (out) : architectural PC
// -----------------------------------------------------------------------------
module branch_sequencer
  import branch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        fetch_req,
  output logic [31:0] fetch_addr,
  input  logic        fetch_ack,
  input  logic        stall,
  input  logic        dec_valid,
  input  logic [4:0]  dec_opcode,
  input  logic [23:0] dec_offset,
  input  logic [31:0] dec_pc,
  input  logic        flags_valid,
  input  logic        flag_z,
  output logic        flush,
  output logic        link_we,
  output logic [31:0] link_data,
  output logic [31:0] pc
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  seq_state_e  state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] target_reg, target_next;
  logic [4:0]  op_reg, op_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic        flush_reg, flush_next;
  logic        link_we_reg, link_we_next;
  logic [31:0] link_data_reg, link_data_next;

  logic [31:0] calc_target;
  logic [31:0] calc_link;
  logic        calc_is_branch;
  logic        calc_is_cond;

  branch_calculator u_calc (
    .dec_pc     (dec_pc),
    .dec_offset (dec_offset),
    .dec_opcode (dec_opcode),
    .target     (calc_target),
    .link_addr  (calc_link),
    .is_branch  (calc_is_branch),
    .is_cond    (calc_is_cond)
  );

  // The one combinational input-to-output path: stall must drop the request
  // in the same cycle it is raised.
  assign fetch_req  = (state_reg == ST_FETCH) && !stall;
  assign fetch_addr = pc_reg;
  assign pc         = pc_reg;
  assign flush      = flush_reg;
  assign link_we    = link_we_reg;
  assign link_data  = link_data_reg;

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    target_next    = target_reg;
    op_next        = op_reg;
    cnt_next       = cnt_reg;
    flush_next     = 1'b0;
    link_we_next   = 1'b0;
    link_data_next = link_data_reg;

    case (state_reg)
      ST_IDLE: state_next = ST_FETCH;

      ST_FETCH: begin
        if (dec_valid && calc_is_branch) begin
          // Branch wins over a coincident fetch_ack: pc is not advanced.
          target_next = calc_target;
          op_next     = dec_opcode;
          if (calc_is_cond) begin
            state_next = ST_RESOLVE;
          end else begin
            // flush/link strobes are registered, so they are raised on the
            // edge that enters REDIRECT.
            state_next = ST_REDIRECT;
            flush_next = 1'b1;
            if (dec_opcode == OP_BL) begin
              link_we_next   = 1'b1;
              link_data_next = calc_link;
            end
          end
        end else if (fetch_req && fetch_ack) begin
          pc_next = pc_reg + 32'd4;
        end
      end

      ST_RESOLVE: begin
        if (flags_valid) begin
          if ((op_reg == OP_BEQ) ? flag_z : !flag_z) begin
            state_next = ST_REDIRECT;
            flush_next = 1'b1;
          end else begin
            state_next = ST_FETCH;
          end
        end
      end

      ST_REDIRECT: begin
        pc_next  = target_reg;
        cnt_next = FLUSH_LOAD;
        if (FLUSH_CYCLES == 1) begin
          state_next = ST_FETCH;
        end else begin
          state_next = ST_FLUSH;
          flush_next = 1'b1;
        end
      end

      ST_FLUSH: begin
        cnt_next = cnt_reg - 3'd1;
        // Leaving as the counter reaches zero; <=1 also guards a stray 0.
        if (cnt_reg <= 3'd1) begin
          state_next = ST_FETCH;
        end else begin
          flush_next = 1'b1;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      pc_reg        <= RESET_VECTOR;
      target_reg    <= 32'd0;
      op_reg        <= 5'd0;
      cnt_reg       <= 3'd0;
      flush_reg     <= 1'b0;
      link_we_reg   <= 1'b0;
      link_data_reg <= 32'd0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      target_reg    <= target_next;
      op_reg        <= op_next;
      cnt_reg       <= cnt_next;
      flush_reg     <= flush_next;
      link_we_reg   <= link_we_next;
      link_data_reg <= link_data_next;
    end
  end

endmodule
